// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit seven-segment scan controller with tear-free frame-boundary updates
module disp_scan_ctrl #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank,
  output logic        ready,
  output logic [3:0]  bcd,
  input  logic [6:0]  sseg_in,
  output logic [6:0]  sseg,
  output logic        dp,
  output logic [3:0]  an
);
  localparam int TW = (DIV > 2) ? $clog2(DIV) : 1;
  typedef enum logic {OFF, SCAN} state_t;
  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [15:0] disp_q, disp_d, pend_q, pend_d;
  logic [3:0]  disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic        pend_v_q, pend_v_d;
  logic [3:0]  an_q, an_d, bcd_q, bcd_d;
  logic        dp_q, dp_d, blank_q, blank_d;
  logic        lit, last, boundary, zero_hi;
  // next-state: load/commit handshake, slot counter and registered digit outputs
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tick_d    = tick_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    pend_v_d  = pend_v_q;
    last      = tick_q == TW'(DIV - 1);
    boundary  = state_q == SCAN && en && last && idx_q == 2'd3;
    lit       = state_q == SCAN && en;
    if (state_q == OFF) begin
      if (load) begin
        state_d   = SCAN;
        disp_d    = value_in;
        disp_dp_d = dp_in;
        idx_d     = 2'd0;
        tick_d    = '0;
      end
    end else begin
      if (en) begin
        tick_d = last ? '0 : tick_q + 1'b1;
        idx_d  = last ? idx_q + 2'd1 : idx_q;
      end
      if (boundary && pend_v_q) begin
        disp_d    = pend_q;
        disp_dp_d = pend_dp_q;
        pend_v_d  = 1'b0;
      end
      if (load && !pend_v_q) begin
        pend_d    = value_in;
        pend_dp_d = dp_in;
        pend_v_d  = 1'b1;
      end
    end
    zero_hi = (disp_q >> {idx_q, 2'b00}) == 16'd0;
    bcd_d   = disp_q[{idx_q, 2'b00} +: 4];
    an_d    = lit ? ~(4'b0001 << idx_q) : 4'hF;
    dp_d    = !(lit && disp_dp_q[idx_q]);
    blank_d = !lit || (lz_blank && idx_q != 2'd0 && zero_hi);
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OFF;
      idx_q     <= 2'd0;
      tick_q    <= '0;
      disp_q    <= 16'd0;
      disp_dp_q <= 4'd0;
      pend_q    <= 16'd0;
      pend_dp_q <= 4'd0;
      pend_v_q  <= 1'b0;
      an_q      <= 4'hF;
      bcd_q     <= 4'd0;
      dp_q      <= 1'b1;
      blank_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tick_q    <= tick_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      pend_v_q  <= pend_v_d;
      an_q      <= an_d;
      bcd_q     <= bcd_d;
      dp_q      <= dp_d;
      blank_q   <= blank_d;
    end
  end
  assign ready = !pend_v_q;
  assign an    = an_q;
  assign bcd   = bcd_q;
  assign dp    = dp_q;
  assign sseg  = blank_q ? 7'h7F : sseg_in;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: randomized and directed checks against a frame-position reference model
module tb_disp_scan_ctrl;
  localparam int DIV = 4;
  localparam int FR = 4 * DIV;
  logic clk = 0, rst, en, load, lz_blank, ready, dp;
  logic [15:0] value_in;
  logic [3:0] dp_in, bcd, an;
  logic [6:0] sseg_in, sseg;
  int checks = 0, errors = 0;
  bit m_on, m_pv, e_blank, e_dp;
  int m_p;
  logic [15:0] m_disp, m_pend;
  logic [3:0] m_ddp, m_pdp, e_an, e_bcd;
  disp_scan_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value_in(value_in), .dp_in(dp_in),
    .lz_blank(lz_blank), .ready(ready), .bcd(bcd), .sseg_in(sseg_in), .sseg(sseg),
    .dp(dp), .an(an)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step();
    bit lit, acc;
    int k;
    if (rst) begin
      m_on = 0; m_p = 0; m_pv = 0; m_disp = 0; m_ddp = 0;
      e_an = 4'hF; e_bcd = 0; e_dp = 1; e_blank = 1;
      return;
    end
    lit = m_on && en;
    k = m_p / DIV;
    e_an = lit ? ~(4'b0001 << k) : 4'hF;
    e_bcd = 4'((m_disp >> (4 * k)) & 16'hF);
    e_dp = !(lit && m_ddp[k]);
    e_blank = !lit || (lz_blank && k > 0 && (m_disp >> (4 * k)) == 0);
    if (!m_on) begin
      if (load) begin
        m_disp = value_in; m_ddp = dp_in; m_on = 1; m_p = 0;
      end
    end else begin
      acc = load && !m_pv;
      if (en && m_p == FR - 1 && m_pv) begin
        m_disp = m_pend; m_ddp = m_pdp; m_pv = 0;
      end
      if (acc) begin
        m_pend = value_in; m_pdp = dp_in; m_pv = 1;
      end
      if (en) m_p = (m_p + 1) % FR;
    end
  endtask
  task automatic cyc(input bit r, input bit e, input bit l, input logic [15:0] v,
                     input logic [3:0] d, input bit lz);
    rst = r; en = e; load = l; value_in = v; dp_in = d; lz_blank = lz;
    sseg_in = 7'($urandom);
    model_step();
    @(posedge clk);
    #1;
    check("an", 16'(an), 16'(e_an));
    check("bcd", 16'(bcd), 16'(e_bcd));
    check("dp", 16'(dp), 16'(e_dp));
    check("sseg", 16'(sseg), e_blank ? 16'h7F : 16'(sseg_in));
    check("ready", 16'(ready), 16'(!m_pv));
  endtask
  task automatic idle(input int n, input bit e, input bit lz);
    for (int i = 0; i < n; i++) cyc(0, e, 0, 16'h0, 4'h0, lz);
  endtask
  initial begin
    m_pend = 0; m_pdp = 0;
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 16'hFFFF, 4'hF, 0);
    check("rst_an", 16'(an), 16'hF);
    check("rst_sseg", 16'(sseg), 16'h7F);
    check("rst_ready", 16'(ready), 16'h1);
    idle(3, 1, 0);
    check("off_an", 16'(an), 16'hF);
    cyc(0, 1, 1, 16'h1234, 4'b0100, 0);
    cyc(0, 1, 0, 16'h0, 4'h0, 0);
    check("first_an", 16'(an), 16'hE);
    check("first_bcd", 16'(bcd), 16'h4);
    idle(FR + DIV, 1, 0);
    cyc(0, 1, 1, 16'hABCD, 4'b0001, 0);
    check("busy", 16'(ready), 16'h0);
    cyc(0, 1, 1, 16'h5555, 4'hF, 0);
    idle(2 * FR, 1, 0);
    while (m_p != FR - 1) cyc(0, 1, 0, 16'h0, 4'h0, 0);
    cyc(0, 1, 1, 16'h9876, 4'h2, 0);
    idle(3 * FR, 1, 0);
    while (m_p != FR - 1) cyc(0, 1, 0, 16'h0, 4'h0, 0);
    cyc(0, 1, 1, 16'h0070, 4'h0, 1);
    idle(3 * FR, 1, 1);
    idle(2 * FR, 1, 0);
    while (m_p != 2 * DIV + 1) cyc(0, 1, 0, 16'h0, 4'h0, 1);
    idle(10, 0, 1);
    idle(FR, 1, 1);
    cyc(0, 1, 1, 16'h4321, 4'h1, 0);
    cyc(1, 1, 1, 16'h1111, 4'h1, 0);
    idle(FR, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      automatic int r = $urandom_range(0, 99);
      cyc(r == 0, r > 9, $urandom_range(0, 7) == 0, 16'($urandom & {16{$urandom_range(0,1) == 1}}),
          4'($urandom), $urandom_range(0, 3) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
